// File: rtl/ifu_inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO with
// registered head outputs, synchronous active-low reset and a flush that empties it.

`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module ifu_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int INST_W = `INST_DATA_WIDTH,
    parameter int ADDR_W = `INST_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_flag_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    input  logic                       is_pred_branch_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic                       is_pred_branch_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [INST_W-1:0] NOP_INST  = INST_W'(`INST_NOP);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(`ZeroWord);

    // Pointer wrap relies on DEPTH being a power of two.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ifu_inst_queue: DEPTH must be a power of two in 2..16");
    end

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [INST_W-1:0] r_inst_mem   [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem   [DEPTH];
    logic              r_branch_mem [DEPTH];

    logic w_push_ready;
    logic w_pop_valid;
    logic w_push;
    logic w_pop;

    // No bypass in either direction: readiness and validity come only from r_count.
    assign w_push_ready = (r_count < FULL_CNT);
    assign w_pop_valid  = (r_count != '0);
    assign w_push       = push_valid_i && w_push_ready && !flush_flag_i;
    assign w_pop        = w_pop_valid && pop_ready_i && !flush_flag_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_flag_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry only becomes visible
    // once count/pointers cover it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_tail]   <= inst_i;
            r_addr_mem[r_tail]   <= inst_addr_i;
            r_branch_mem[r_tail] <= is_pred_branch_i;
        end
    end

    assign push_ready_o     = w_push_ready;
    assign pop_valid_o      = w_pop_valid;
    assign count_o          = r_count;
    assign inst_o           = w_pop_valid ? r_inst_mem[r_head]   : NOP_INST;
    assign inst_addr_o      = w_pop_valid ? r_addr_mem[r_head]   : ZERO_ADDR;
    assign is_pred_branch_o = w_pop_valid ? r_branch_mem[r_head] : 1'b0;

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed self-checking bench for ifu_inst_queue (DEPTH=4, 32-bit instruction/address).

module tb_ifu_inst_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_flag_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        is_pred_branch_i;
    logic        pop_valid_o;
    logic        pop_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        is_pred_branch_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_inst_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_flag_i     (flush_flag_i),
        .push_valid_i     (push_valid_i),
        .push_ready_o     (push_ready_o),
        .inst_i           (inst_i),
        .inst_addr_i      (inst_addr_i),
        .is_pred_branch_i (is_pred_branch_i),
        .pop_valid_o      (pop_valid_o),
        .pop_ready_i      (pop_ready_i),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o),
        .is_pred_branch_o (is_pred_branch_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge; outputs are sampled 1 ns later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_flag_i     = 1'b0;
        push_valid_i     = 1'b0;
        pop_ready_i      = 1'b0;
        inst_i           = 32'h0;
        inst_addr_i      = 32'h0;
        is_pred_branch_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_entry(input logic [31:0] d, input logic [31:0] a, input logic b);
        push_valid_i     = 1'b1;
        inst_i           = d;
        inst_addr_i      = a;
        is_pred_branch_i = b;
        tick();
        push_valid_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        tick();
        do_reset();
        n_checks++;
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_checks++;
        if (pop_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid_o); end
        n_checks++;
        if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b expected 1", push_ready_o); end
        n_checks++;
        if (inst_o !== NOP || inst_addr_o !== 32'h0 || is_pred_branch_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h@%h/%b expected %h@00000000/0", inst_o, inst_addr_o, is_pred_branch_o, NOP);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push_entry(32'h0000_0013, 32'h8000_0000, 1'b0);
        n_checks++;
        if (count_o !== 3'd1) begin n_fail++; $display("FAIL basic_count1: got %0d expected 1", count_o); end
        n_checks++;
        if (pop_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || inst_addr_o !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL basic_head1: got v=%b %h@%h expected v=1 00000013@80000000", pop_valid_o, inst_o, inst_addr_o);
        end
        push_entry(32'h0010_0093, 32'h8000_0004, 1'b1);
        n_checks++;
        if (count_o !== 3'd2) begin n_fail++; $display("FAIL basic_count2: got %0d expected 2", count_o); end
        n_checks++;
        if (inst_o !== 32'h0000_0013 || inst_addr_o !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL basic_head_stall: got %h@%h expected 00000013@80000000", inst_o, inst_addr_o);
        end
        pop_ready_i = 1'b1;
        tick();
        n_checks++;
        if (count_o !== 3'd1 || inst_o !== 32'h0010_0093 || inst_addr_o !== 32'h8000_0004 || is_pred_branch_o !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pop1: got c=%0d %h@%h/%b expected c=1 00100093@80000004/1", count_o, inst_o, inst_addr_o, is_pred_branch_o);
        end
        tick();
        pop_ready_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd0 || pop_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_empty: got c=%0d v=%b %h@%h expected c=0 v=0 %h@00000000", count_o, pop_valid_o, inst_o, inst_addr_o, NOP);
        end
    endtask

    // Fill past capacity, then drain; also covers the full-queue push+pop cycle.
    task automatic test_full();
        logic [31:0] e [5];
        for (int k = 0; k < 5; k++) e[k] = 32'hA000_0000 | k;
        do_reset();
        for (int k = 0; k < 4; k++) push_entry(e[k], 32'h0000_1000 + 32'(4 * k), k[0]);
        n_checks++;
        if (count_o !== 3'd4 || push_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after4: got c=%0d rdy=%b expected c=4 rdy=0", count_o, push_ready_o);
        end
        push_valid_i = 1'b1;
        inst_i = e[4];
        inst_addr_i = 32'h0000_1010;
        is_pred_branch_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (count_o !== 3'd4 || inst_o !== e[0]) begin
            n_fail++;
            $display("FAIL full_holdoff: got c=%0d head=%h expected c=4 head=%h", count_o, inst_o, e[0]);
        end
        pop_ready_i = 1'b1;
        tick();
        n_checks++;
        if (count_o !== 3'd3 || inst_o !== e[1] || push_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_only: got c=%0d head=%h rdy=%b expected c=3 head=%h rdy=1", count_o, inst_o, push_ready_o, e[1]);
        end
        tick();
        push_valid_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd3 || inst_o !== e[2]) begin
            n_fail++;
            $display("FAIL full_push_pop: got c=%0d head=%h expected c=3 head=%h", count_o, inst_o, e[2]);
        end
        tick();
        n_checks++;
        if (count_o !== 3'd2 || inst_o !== e[3] || is_pred_branch_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain3: got c=%0d head=%h/%b expected c=2 head=%h/1", count_o, inst_o, is_pred_branch_o, e[3]);
        end
        tick();
        n_checks++;
        if (count_o !== 3'd1 || inst_o !== e[4] || inst_addr_o !== 32'h0000_1010) begin
            n_fail++;
            $display("FAIL full_drain4: got c=%0d head=%h@%h expected c=1 head=%h@00001010", count_o, inst_o, inst_addr_o, e[4]);
        end
        tick();
        pop_ready_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd0 || pop_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: got c=%0d v=%b expected c=0 v=0", count_o, pop_valid_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) push_entry(32'hB000_0000 | k, 32'h0000_2000 + 32'(4 * k), 1'b1);
        flush_flag_i = 1'b1;
        push_valid_i = 1'b1;
        pop_ready_i  = 1'b1;
        inst_i       = 32'hDEAD_BEEF;
        inst_addr_i  = 32'h0000_3000;
        #1;
        n_checks++;
        if (pop_valid_o !== 1'b1 || inst_o !== 32'hB000_0000) begin
            n_fail++;
            $display("FAIL flush_cycle_head: got v=%b %h expected v=1 b0000000", pop_valid_o, inst_o);
        end
        tick();
        flush_flag_i = 1'b0;
        push_valid_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd0 || pop_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_empty: got c=%0d v=%b %h@%h expected c=0 v=0 %h@00000000", count_o, pop_valid_o, inst_o, inst_addr_o, NOP);
        end
        tick();
        pop_ready_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd0 || pop_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_push_dropped: got c=%0d v=%b expected c=0 v=0", count_o, pop_valid_o);
        end
        push_entry(32'hC000_0001, 32'h0000_4000, 1'b0);
        n_checks++;
        if (count_o !== 3'd1 || inst_o !== 32'hC000_0001 || inst_addr_o !== 32'h0000_4000) begin
            n_fail++;
            $display("FAIL flush_restart: got c=%0d %h@%h expected c=1 c0000001@00004000", count_o, inst_o, inst_addr_o);
        end
    endtask

    // 3*DEPTH entries streamed with two in flight; wraps both pointers several times.
    task automatic test_back_to_back();
        int rd = 0;
        int budget;
        do_reset();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_valid_i     = 1'b1;
            inst_i           = 32'hD000_0000 | i;
            inst_addr_i      = 32'h0001_0000 + 32'(4 * i);
            is_pred_branch_i = ((i % 3) == 2);
            pop_ready_i      = (i >= 2);
            #1;
            if (pop_valid_o && pop_ready_i) begin
                n_checks++;
                if (inst_o !== (32'hD000_0000 | rd) || inst_addr_o !== 32'h0001_0000 + 32'(4 * rd) || is_pred_branch_o !== ((rd % 3) == 2)) begin
                    n_fail++;
                    $display("FAIL stream_out%0d: got %h@%h/%b expected %h@%h/%b", rd, inst_o, inst_addr_o, is_pred_branch_o,
                             32'hD000_0000 | rd, 32'h0001_0000 + 32'(4 * rd), ((rd % 3) == 2));
                end
                rd++;
            end
            tick();
            if (i >= 1) begin
                n_checks++;
                if (count_o !== 3'd2) begin n_fail++; $display("FAIL stream_count%0d: got %0d expected 2", i, count_o); end
            end
        end
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b1;
        budget = 8;
        while (rd < 3 * DEPTH && budget > 0) begin
            budget--;
            if (pop_valid_o) begin
                n_checks++;
                if (inst_o !== (32'hD000_0000 | rd) || is_pred_branch_o !== ((rd % 3) == 2)) begin
                    n_fail++;
                    $display("FAIL stream_drain%0d: got %h/%b expected %h/%b", rd, inst_o, is_pred_branch_o, 32'hD000_0000 | rd, ((rd % 3) == 2));
                end
                rd++;
            end
            tick();
        end
        pop_ready_i = 1'b0;
        n_checks++;
        if (rd !== 3 * DEPTH || pop_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_complete: got %0d entries v=%b expected %0d entries v=0", rd, pop_valid_o, 3 * DEPTH);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        for (int k = 0; k < 4; k++) push_entry(32'hE000_0000 | k, 32'h0000_5000 + 32'(4 * k), 1'b0);
        rst_n        = 1'b0;
        push_valid_i = 1'b1;
        pop_ready_i  = 1'b1;
        tick();
        rst_n        = 1'b1;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        n_checks++;
        if (count_o !== 3'd0 || push_ready_o !== 1'b1 || pop_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full: got c=%0d rdy=%b v=%b expected c=0 rdy=1 v=0", count_o, push_ready_o, pop_valid_o);
        end
        n_checks++;
        if (inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_full_outputs: got %h@%h expected %h@00000000", inst_o, inst_addr_o, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_back_to_back();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_inst_queue.md
IFU_INST_QUEUE -- requirements
Module: ifu_inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two, 2..16.
REQ-002 Parameter INST_W, default `INST_DATA_WIDTH, SHALL set the instruction width.
REQ-003 Parameter ADDR_W, default `INST_ADDR_WIDTH, SHALL set the instruction address width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 flush_flag_i  in  1  SHALL be the pipeline flush request.
REQ-007 push_valid_i  in  1  SHALL indicate that the fetch side presents an entry.
REQ-008 push_ready_o  out  1  SHALL indicate that the queue accepts an entry this cycle.
REQ-009 inst_i  in  INST_W  SHALL be the fetched instruction.
REQ-010 inst_addr_i  in  ADDR_W  SHALL be the fetched instruction address.
REQ-011 is_pred_branch_i  in  1  SHALL be the predicted-taken-branch flag of the fetched instruction.
REQ-012 pop_valid_o  out  1  SHALL indicate that the head entry is valid for decode.
REQ-013 pop_ready_i  in  1  SHALL indicate that decode consumes the head entry (low = stall).
REQ-014 inst_o  out  INST_W  SHALL be the head instruction.
REQ-015 inst_addr_o  out  ADDR_W  SHALL be the head instruction address.
REQ-016 is_pred_branch_o  out  1  SHALL be the head predicted-branch flag.
REQ-017 count_o  out  $clog2(DEPTH+1)  SHALL be the current number of stored entries.

Function
REQ-018 Push SHALL occur when push_valid_i && push_ready_o && !flush_flag_i; the entry is written at the tail pointer, which then increments modulo DEPTH.
REQ-019 Pop SHALL occur when pop_valid_o && pop_ready_i && !flush_flag_i; the head pointer then increments modulo DEPTH.
REQ-020 push_ready_o SHALL equal (count_o < DEPTH); no full-queue bypass, so a push is refused when full even if a pop occurs the same cycle.
REQ-021 pop_valid_o SHALL equal (count_o != 0); there is no empty-queue bypass, so a pushed entry first appears at the outputs in the cycle after the push (latency 1).
REQ-022 count_o SHALL be incremented by push-only, decremented by pop-only, and unchanged by simultaneous push and pop or by neither.
REQ-023 When pop_valid_o is 1, inst_o/inst_addr_o/is_pred_branch_o SHALL be the fields of the head entry, driven from storage registers with no combinational path from any input.
REQ-024 When pop_valid_o is 0, inst_o SHALL be `INST_NOP, inst_addr_o `ZeroWord and is_pred_branch_o 0.
REQ-025 Entries SHALL leave the queue in push order; pointer wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-026 flush_flag_i=1 SHALL, at the next edge, zero head pointer, tail pointer and count; any push or pop in that cycle is discarded.
REQ-027 Flush SHALL take priority over push and pop; outputs in the flush cycle still show the pre-flush head.
REQ-028 Storage array contents need no reset or clear; validity is defined solely by count and pointers.

Reset
REQ-029 With rst_n=0 at a rising edge, head pointer, tail pointer and count SHALL become 0, giving pop_valid_o=0, push_ready_o=1, count_o=0 and NOP/zero outputs per REQ-024.
REQ-030 Reset SHALL take priority over flush, push and pop, including mid-stream with a full queue.

Verification
REQ-031 After reset, push 0x00000013@0x80000000 then 0x00100093@0x80000004 with pop_ready_i=0 -> count_o 1 then 2; inst_o=0x00000013, inst_addr_o=0x80000000 from cycle after first push.
REQ-032 DEPTH=4, push 5 entries with pop_ready_i=0 -> push_ready_o=0 after 4th, 5th held off, count_o=4; raise pop_ready_i -> entries emerge in order, 5th accepted only after a slot frees.
REQ-033 Full queue, push_valid_i=1 and pop_ready_i=1 same cycle -> pop only, count_o 4->3, next cycle push accepted and count_o stays 3.
REQ-034 Queue holding 3 entries, flush_flag_i=1 with push_valid_i=1 -> next cycle count_o=0, pop_valid_o=0, inst_o=`INST_NOP, inst_addr_o=0; pushed entry never appears.
REQ-035 Continuous push/pop for 3*DEPTH entries with is_pred_branch_i on every third -> output order and flags match input exactly across pointer wrap, count_o constant at steady state.
REQ-036 Full queue, rst_n=0 for one cycle with flush_flag_i=0 -> count_o=0, push_ready_o=1, pop_valid_o=0 next cycle.
